// File: rtl/smart_guard_if.sv
// -----------------------------------------------------------------------------
// smart_guard_if
// Bundles the CPU fetch/data, DMA and control signals seen by the SMART guard
// controller together with its status outputs.
//
// Handshake semantics: there is no back-pressure. ins_valid, mem_en and dma_en
// are per-cycle qualifiers. The guard samples an address only in a cycle where
// its qualifier is 1, and it never stalls the bus. Enforcement is carried out
// through mem_block (same cycle) and sys_reset (registered).
//
// Modports:
//   master : CPU/DMA/control side; drives the requests and reads the status.
//   slave  : guard side; reads the requests and drives the status.
//
// Signals:
//   ins_addr[15:0], ins_valid       instruction fetch address / new-fetch strobe
//   mem_addr[SIZE_MEM_ADDR:0], mem_en  CPU data access
//   dma_addr[SIZE_MEM_ADDR:0], dma_en  DMA access
//   disable_debug                   1 = log violations only
//   clr_viol                        clear sticky cause and counter
//   in_safe_area, sys_reset         registered status
//   mem_block                       combinational read-data gate
//   viol_cause[2:0], viol_count[CNT_W-1:0]  sticky violation status
// -----------------------------------------------------------------------------
interface smart_guard_if #(
  parameter int SIZE_MEM_ADDR = 15,
  parameter int CNT_W         = 8
);
  logic [15:0]            ins_addr;
  logic                   ins_valid;
  logic [SIZE_MEM_ADDR:0] mem_addr;
  logic                   mem_en;
  logic [SIZE_MEM_ADDR:0] dma_addr;
  logic                   dma_en;
  logic                   disable_debug;
  logic                   clr_viol;
  logic                   in_safe_area;
  logic                   sys_reset;
  logic                   mem_block;
  logic [2:0]             viol_cause;
  logic [CNT_W-1:0]       viol_count;

  modport master (
    output ins_addr, ins_valid, mem_addr, mem_en, dma_addr, dma_en,
           disable_debug, clr_viol,
    input  in_safe_area, sys_reset, mem_block, viol_cause, viol_count
  );

  modport slave (
    input  ins_addr, ins_valid, mem_addr, mem_en, dma_addr, dma_en,
           disable_debug, clr_viol,
    output in_safe_area, sys_reset, mem_block, viol_cause, viol_count
  );
endinterface

// File: rtl/smart_guard_ctrl.sv
// -----------------------------------------------------------------------------
// smart_guard_ctrl
// Sequencing controller for the SMART protected region. It tracks entry into
// and exit from trusted code, and it classifies illegal CPU and DMA accesses to
// the safe (key) area. On a violation it drives a fixed-length device reset and
// keeps sticky violation status.
//
// Ports:
//   mclk         clock; all state changes on its rising edge
//   reset        asynchronous, active-high reset
//   bus          smart_guard_if.slave (requests in, status out)
//   o_dbg_state  current FSM state (0=UNTRUSTED, 1=TRUSTED, 2=RESETTING)
// -----------------------------------------------------------------------------
module smart_guard_ctrl #(
  parameter int          SIZE_MEM_ADDR = 15,
  parameter int unsigned LOW_SAFE      = 200,
  parameter int unsigned HIGH_SAFE     = 200,
  parameter int unsigned LOW_CODE      = 200,
  parameter int unsigned HIGH_CODE     = 200,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int          CNT_W         = 8
) (
  input  logic              mclk,
  input  logic              reset,
  smart_guard_if.slave      bus,
  output logic [1:0]        o_dbg_state
);

  localparam int AW     = SIZE_MEM_ADDR + 1;
  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [AW-1:0]     SAFE_LO   = AW'(LOW_SAFE);
  localparam logic [AW-1:0]     SAFE_HI   = AW'(HIGH_SAFE);
  localparam logic [15:0]       CODE_LO   = 16'(LOW_CODE);
  localparam logic [15:0]       CODE_HI   = 16'(HIGH_CODE);
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_UNTRUSTED = 2'd0,
    ST_TRUSTED   = 2'd1,
    ST_RESETTING = 2'd2
  } state_t;

  state_t            r_state;
  logic [RCNT_W-1:0] r_rcnt;
  logic              r_in_safe;
  logic              r_sys_reset;
  logic [2:0]        r_viol_cause;
  logic [CNT_W-1:0]  r_viol_count;

  // ---------------------------------------------------------------------------
  // Address classification
  // ---------------------------------------------------------------------------
  logic w_in_code;
  logic w_is_entry;
  logic w_mem_safe;
  logic w_dma_safe;

  assign w_in_code  = (bus.ins_addr >= CODE_LO) && (bus.ins_addr <= CODE_HI);
  assign w_is_entry = (bus.ins_addr == CODE_LO);
  assign w_mem_safe = (bus.mem_addr >= SAFE_LO) && (bus.mem_addr <= SAFE_HI);
  assign w_dma_safe = (bus.dma_addr >= SAFE_LO) && (bus.dma_addr <= SAFE_HI);

  // ---------------------------------------------------------------------------
  // Violation terms. The device is already being reset while RESETTING, so
  // nothing seen during the pulse is classified, logged or counted.
  // ---------------------------------------------------------------------------
  logic w_active;
  logic w_v_entry;
  logic w_v_data;
  logic w_v_dma;
  logic w_viol;
  logic w_enforce;
  logic [2:0] w_cause_set;

  assign w_active  = (r_state != ST_RESETTING);
  // A jump into the middle of trusted code is illegal. Only the entry point may
  // be the first trusted fetch.
  assign w_v_entry = w_active & bus.ins_valid & w_in_code &
                     (r_state == ST_UNTRUSTED) & ~w_is_entry;
  assign w_v_data  = w_active & bus.mem_en & w_mem_safe & (r_state != ST_TRUSTED);
  // The key area is never a legal DMA target, not even from trusted code.
  assign w_v_dma   = w_active & bus.dma_en & w_dma_safe;
  assign w_viol    = w_v_entry | w_v_data | w_v_dma;
  // With disable_debug set, violations are only logged and never enforced.
  assign w_enforce = w_viol & ~bus.disable_debug;
  assign w_cause_set = {w_v_dma, w_v_data, w_v_entry};

  // ---------------------------------------------------------------------------
  // Sequencing FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_UNTRUSTED;
      r_rcnt      <= '0;
      r_in_safe   <= 1'b0;
      r_sys_reset <= 1'b0;
    end else begin
      case (r_state)
        ST_UNTRUSTED: begin
          // A violation has priority over entry in the same cycle.
          if (w_enforce) begin
            r_state     <= ST_RESETTING;
            r_rcnt      <= RCNT_LOAD;
            r_sys_reset <= 1'b1;
            r_in_safe   <= 1'b0;
          end else if (bus.ins_valid && w_is_entry) begin
            r_state   <= ST_TRUSTED;
            r_in_safe <= 1'b1;
          end
        end
        ST_TRUSTED: begin
          // A violation has priority over exit in the same cycle.
          if (w_enforce) begin
            r_state     <= ST_RESETTING;
            r_rcnt      <= RCNT_LOAD;
            r_sys_reset <= 1'b1;
            r_in_safe   <= 1'b0;
          end else if (bus.ins_valid && !w_in_code) begin
            r_state   <= ST_UNTRUSTED;
            r_in_safe <= 1'b0;
          end
        end
        ST_RESETTING: begin
          // The counter is loaded with RST_CYCLES-1. The state is left at
          // zero, so the pulse lasts exactly RST_CYCLES cycles.
          if (r_rcnt == '0) begin
            r_state     <= ST_UNTRUSTED;
            r_sys_reset <= 1'b0;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
        default: begin
          r_state     <= ST_UNTRUSTED;
          r_rcnt      <= '0;
          r_in_safe   <= 1'b0;
          r_sys_reset <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky violation status. New bits set in the same cycle as clr_viol are
  // kept, so a clear can never hide a fresh violation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_viol_cause <= 3'b000;
      r_viol_count <= '0;
    end else begin
      if (bus.clr_viol) begin
        r_viol_cause <= w_cause_set;
        r_viol_count <= w_viol ? CNT_ONE : '0;
      end else begin
        r_viol_cause <= r_viol_cause | w_cause_set;
        if (w_viol && (r_viol_count != CNT_MAX)) begin
          r_viol_count <= r_viol_count + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Read data is gated in the same cycle as the offending access, and for the
  // whole reset pulse.
  assign bus.mem_block    = ((w_v_data | w_v_dma) & ~bus.disable_debug) |
                            (r_state == ST_RESETTING);
  assign bus.in_safe_area = r_in_safe;
  assign bus.sys_reset    = r_sys_reset;
  assign bus.viol_cause   = r_viol_cause;
  assign bus.viol_count   = r_viol_count;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_smart_guard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_smart_guard_ctrl
// DUT A uses the default ranges (code 200..200, safe 200..200).
// DUT B uses code 100..120 to exercise the mid-range entry rule.
// -----------------------------------------------------------------------------
module tb_smart_guard_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic mclk  = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 mclk = ~mclk;

  smart_guard_if #(.SIZE_MEM_ADDR(15), .CNT_W(8)) ifa ();
  smart_guard_if #(.SIZE_MEM_ADDR(15), .CNT_W(8)) ifb ();
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  smart_guard_ctrl #(
    .SIZE_MEM_ADDR(15), .LOW_SAFE(200), .HIGH_SAFE(200),
    .LOW_CODE(200), .HIGH_CODE(200), .RST_CYCLES(16), .CNT_W(8)
  ) u_dut_a (
    .mclk(mclk), .reset(rst_a), .bus(ifa), .o_dbg_state(dbg_a)
  );

  smart_guard_ctrl #(
    .SIZE_MEM_ADDR(15), .LOW_SAFE(200), .HIGH_SAFE(200),
    .LOW_CODE(100), .HIGH_CODE(120), .RST_CYCLES(16), .CNT_W(8)
  ) u_dut_b (
    .mclk(mclk), .reset(rst_b), .bus(ifb), .o_dbg_state(dbg_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (both DUTs see the same stimulus)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [15:0] ia, input logic iv,
                       input logic [15:0] ma, input logic me,
                       input logic [15:0] da, input logic de,
                       input logic dd, input logic clr);
    ifa.ins_addr = ia; ifa.ins_valid = iv; ifa.mem_addr = ma; ifa.mem_en = me;
    ifa.dma_addr = da; ifa.dma_en = de; ifa.disable_debug = dd; ifa.clr_viol = clr;
    ifb.ins_addr = ia; ifb.ins_valid = iv; ifb.mem_addr = ma; ifb.mem_en = me;
    ifb.dma_addr = da; ifb.dma_en = de; ifb.disable_debug = dd; ifb.clr_viol = clr;
  endtask

  task automatic idle();
    drive(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Idle until sys_reset of the chosen DUT drops, with a cycle budget.
  task automatic wait_pulse_end(input string name, input logic sel_b);
    int n;
    n = 0;
    idle();
    while ((sel_b ? ifb.sys_reset : ifa.sys_reset) && n < 100) begin
      step();
      n++;
    end
    check(name, {31'd0, (sel_b ? ifb.sys_reset : ifa.sys_reset)}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] ia; logic iv;
    logic [15:0] ma; logic me;
    logic [15:0] da; logic de;
    logic dd; logic clr;
    logic e_mb; logic e_safe; logic e_sr;
    logic [2:0] e_cause; logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  initial begin
    int pulse;
    int k;
    logic seen_bad;

    //         ia   iv  ma   me  da   de  dd clr  mb safe sr cause cnt
    vecs[0]  = '{16'd0,   0, 16'd0,   0, 16'd0,   0, 0, 0, 0, 0, 0, 3'd0, 8'd0};
    vecs[1]  = '{16'd200, 1, 16'd0,   0, 16'd0,   0, 0, 0, 0, 1, 0, 3'd0, 8'd0};
    vecs[2]  = '{16'd0,   0, 16'd200, 1, 16'd0,   0, 0, 0, 0, 1, 0, 3'd0, 8'd0};
    vecs[3]  = '{16'd300, 1, 16'd0,   0, 16'd0,   0, 0, 0, 0, 0, 0, 3'd0, 8'd0};
    vecs[4]  = '{16'd200, 1, 16'd0,   0, 16'd0,   0, 0, 0, 0, 1, 0, 3'd0, 8'd0};
    vecs[5]  = '{16'd201, 1, 16'd0,   0, 16'd0,   0, 0, 0, 0, 0, 0, 3'd0, 8'd0};
    vecs[6]  = '{16'd0,   0, 16'd199, 1, 16'd0,   0, 0, 0, 0, 0, 0, 3'd0, 8'd0};
    vecs[7]  = '{16'd0,   0, 16'd201, 1, 16'd0,   0, 0, 0, 0, 0, 0, 3'd0, 8'd0};
    vecs[8]  = '{16'd0,   0, 16'd200, 1, 16'd0,   0, 1, 0, 0, 0, 0, 3'd2, 8'd1};
    vecs[9]  = '{16'd0,   0, 16'd0,   0, 16'd0,   0, 0, 1, 0, 0, 0, 3'd0, 8'd0};
    vecs[10] = '{16'd0,   0, 16'd0,   0, 16'd200, 1, 1, 0, 0, 0, 0, 3'd4, 8'd1};
    vecs[11] = '{16'd0,   0, 16'd0,   0, 16'd200, 1, 1, 1, 0, 0, 0, 3'd4, 8'd1};
    vecs[12] = '{16'd0,   0, 16'd0,   0, 16'd0,   0, 0, 1, 0, 0, 0, 3'd0, 8'd0};
    vecs[13] = '{16'd200, 1, 16'd200, 1, 16'd0,   0, 1, 0, 0, 1, 0, 3'd2, 8'd1};
    vecs[14] = '{16'd300, 1, 16'd0,   0, 16'd0,   0, 0, 1, 0, 0, 0, 3'd0, 8'd0};

    // ---- reset ----
    idle();
    @(negedge mclk);
    @(negedge mclk);
    rst_a = 1'b0;
    #1;
    check("rst_safe",  {31'd0, ifa.in_safe_area}, 32'd0);
    check("rst_sr",    {31'd0, ifa.sys_reset},    32'd0);
    check("rst_mb",    {31'd0, ifa.mem_block},    32'd0);
    check("rst_cause", {29'd0, ifa.viol_cause},   32'd0);
    check("rst_cnt",   {24'd0, ifa.viol_count},   32'd0);
    check("rst_state", {30'd0, dbg_a},            32'd0);
    step();

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ia, vecs[i].iv, vecs[i].ma, vecs[i].me,
            vecs[i].da, vecs[i].de, vecs[i].dd, vecs[i].clr);
      #1;
      check($sformatf("v%0d_mb", i), {31'd0, ifa.mem_block}, {31'd0, vecs[i].e_mb});
      step();
      check($sformatf("v%0d_safe", i), {31'd0, ifa.in_safe_area}, {31'd0, vecs[i].e_safe});
      check($sformatf("v%0d_sr", i), {31'd0, ifa.sys_reset}, {31'd0, vecs[i].e_sr});
      check($sformatf("v%0d_cause", i), {29'd0, ifa.viol_cause}, {29'd0, vecs[i].e_cause});
      check($sformatf("v%0d_cnt", i), {24'd0, ifa.viol_count}, {24'd0, vecs[i].e_cnt});
    end

    // ---- untrusted data access: same-cycle block and a 16-cycle pulse ----
    drive(16'd0, 1'b0, 16'd200, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("data_mb", {31'd0, ifa.mem_block}, 32'd1);
    step();
    check("data_cause", {29'd0, ifa.viol_cause}, 32'd2);
    check("data_cnt",   {24'd0, ifa.viol_count}, 32'd1);
    check("data_sr",    {31'd0, ifa.sys_reset},  32'd1);
    check("data_state", {30'd0, dbg_a},          32'd2);
    pulse = 1;
    k = 0;
    while (ifa.sys_reset && pulse < 100) begin
      k++;
      if (k == 3) drive(16'd0, 1'b0, 16'd200, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
      else idle();
      #1;
      if (k == 3) check("resetting_mb", {31'd0, ifa.mem_block}, 32'd1);
      step();
      if (k == 3) check("resetting_cnt_frozen", {24'd0, ifa.viol_count}, 32'd1);
      if (ifa.sys_reset) pulse++;
    end
    check("pulse_len",        pulse,                   32'd16);
    check("pulse_end_state",  {30'd0, dbg_a},          32'd0);
    check("pulse_keep_cause", {29'd0, ifa.viol_cause}, 32'd2);

    // ---- DMA while TRUSTED ----
    drive(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    step();
    drive(16'd200, 1'b1, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("dma_pre_safe", {31'd0, ifa.in_safe_area}, 32'd1);
    drive(16'd0, 1'b0, 16'd0, 1'b0, 16'd200, 1'b1, 1'b0, 1'b0);
    #1;
    check("dma_mb", {31'd0, ifa.mem_block}, 32'd1);
    step();
    check("dma_cause", {29'd0, ifa.viol_cause},   32'd4);
    check("dma_sr",    {31'd0, ifa.sys_reset},    32'd1);
    check("dma_safe",  {31'd0, ifa.in_safe_area}, 32'd0);
    wait_pulse_end("dma_pulse_end", 1'b0);

    // ---- DUT B: mid-range entry, then normal entry and exit ----
    idle();
    rst_b = 1'b0;
    drive(16'd110, 1'b1, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("mid_cause", {29'd0, ifb.viol_cause}, 32'd1);
    check("mid_sr",    {31'd0, ifb.sys_reset},  32'd1);
    wait_pulse_end("mid_pulse_end", 1'b1);
    drive(16'd100, 1'b1, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("b_entry_safe", {31'd0, ifb.in_safe_area}, 32'd1);
    drive(16'd130, 1'b1, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("b_exit_safe",  {31'd0, ifb.in_safe_area}, 32'd0);
    check("b_exit_sr",    {31'd0, ifb.sys_reset},    32'd0);
    check("b_exit_cause", {29'd0, ifb.viol_cause},   32'd1);
    check("b_exit_cnt",   {24'd0, ifb.viol_count},   32'd1);

    // ---- disable_debug: counter saturation, no enforcement ----
    drive(16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    step();
    seen_bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(16'd0, 1'b0, 16'd200, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0);
      #1;
      if (ifa.mem_block) seen_bad = 1'b1;
      step();
      if (ifa.sys_reset) seen_bad = 1'b1;
    end
    check("dd_no_enforce", {31'd0, seen_bad},       32'd0);
    check("dd_sat_cnt",    {24'd0, ifa.viol_count}, 32'd255);
    check("dd_state",      {30'd0, dbg_a},          32'd0);
    drive(16'd0, 1'b0, 16'd200, 1'b1, 16'd0, 1'b0, 1'b1, 1'b1);
    step();
    check("clr_with_viol_cnt",   {24'd0, ifa.viol_count}, 32'd1);
    check("clr_with_viol_cause", {29'd0, ifa.viol_cause}, 32'd2);

    // ---- reset in the middle of a pulse ----
    drive(16'd0, 1'b0, 16'd200, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("mid_rst_pre_sr", {31'd0, ifa.sys_reset}, 32'd1);
    idle();
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_a = 1'b1;
    #1;
    check("async_rst_sr",    {31'd0, ifa.sys_reset},    32'd0);
    check("async_rst_mb",    {31'd0, ifa.mem_block},    32'd0);
    check("async_rst_safe",  {31'd0, ifa.in_safe_area}, 32'd0);
    check("async_rst_cause", {29'd0, ifa.viol_cause},   32'd0);
    check("async_rst_cnt",   {24'd0, ifa.viol_count},   32'd0);
    check("async_rst_state", {30'd0, dbg_a},            32'd0);
    @(negedge mclk);
    rst_a = 1'b0;
    step();
    check("post_rst_sr", {31'd0, ifa.sys_reset}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
